// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    HOLD_BR = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'hBFC0_0380;
  localparam int unsigned PC_INC          = 4;

endpackage : pc_pkg

// File: rtl/pc_redirect_hold.sv
// Holds a branch target that was resolved while fetch was stalled.
// load captures a new target, clear discards it (flush), release
// consumes it once fetch advances. clear wins over load.
module pc_redirect_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             release_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] target_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] target_q, target_d;
  logic             valid_q, valid_d;

  // Next value of the held target and its valid flag.
  always_comb begin
    target_d = target_q;
    valid_d  = valid_q;
    if (clear_i) begin
      target_d = '0;
      valid_d  = 1'b0;
    end else if (load_i) begin
      target_d = target_i;
      valid_d  = 1'b1;
    end else if (release_i) begin
      valid_d  = 1'b0;
    end
  end

  // Target and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q  <= valid_d;
    end
  end

  assign target_o = target_q;
  assign valid_o  = valid_q;

endmodule : pc_redirect_hold

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential increment, branch redirect
// (deferred across stalls), exception vector and ERET return.
//
// state   | meaning
// RUN     | normal fetch
// HOLD_BR | branch target latched during a stall, waiting for en
module pc_gen
  import pc_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
  parameter int unsigned       INC          = PC_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             branch_valid_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             exc_valid_i,
  input  logic             exc_eret_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_inc_o,
  output logic             redirect_pending_o,
  output logic             pc_misaligned_o
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             hold_load, hold_clear, hold_release;
  logic [WIDTH-1:0] hold_target;
  logic             hold_valid;

  assign pc_plus_inc = pc_q + WIDTH'(INC);

  pc_redirect_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hold_load),
    .clear_i   (hold_clear),
    .release_i (hold_release),
    .target_i  (branch_target_i),
    .target_o  (hold_target),
    .valid_o   (hold_valid)
  );

  // Next-PC selection and state transitions; a flush beats everything,
  // including a stall and a pending redirect.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    hold_release = 1'b0;
    if (exc_valid_i) begin
      pc_d       = exc_eret_i ? epc_i : EXC_VECTOR;
      state_d    = RUN;
      hold_clear = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en_i) begin
            pc_d = branch_valid_i ? branch_target_i : pc_plus_inc;
          end else if (branch_valid_i) begin
            hold_load = 1'b1;
            state_d   = HOLD_BR;
          end
        end
        HOLD_BR: begin
          // A second branch here would sit in a delay slot; it is ignored.
          if (en_i) begin
            pc_d         = hold_target;
            hold_release = 1'b1;
            state_d      = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // PC and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_o               = pc_q;
  assign pc_plus_inc_o      = pc_plus_inc;
  assign redirect_pending_o = hold_valid;
  assign pc_misaligned_o    = |pc_q[1:0];

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed test of pc_gen with hand-computed expected values.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        exc_valid;
  logic        exc_eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        redirect_pending;
  logic        pc_misaligned;

  int n_checks = 0;
  int n_fails  = 0;

  pc_gen #(
    .WIDTH (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .en_i               (en),
    .branch_valid_i     (branch_valid),
    .branch_target_i    (branch_target),
    .exc_valid_i        (exc_valid),
    .exc_eret_i         (exc_eret),
    .epc_i              (epc),
    .pc_o               (pc),
    .pc_plus_inc_o      (pc_plus_inc),
    .redirect_pending_o (redirect_pending),
    .pc_misaligned_o    (pc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; branch_valid = 1'b0; branch_target = '0;
    exc_valid = 1'b0; exc_eret = 1'b0; epc = '0;
    #3;
    check("reset_pc", pc, 32'hBFC00000);
    check("reset_pend", {31'd0, redirect_pending}, 32'd0);
    check("reset_mis", {31'd0, pc_misaligned}, 32'd0);
    check("reset_inc", pc_plus_inc, 32'hBFC00004);
    tick();
    rst = 1'b0;
    check("post_rst_pc", pc, 32'hBFC00000);

    // Sequential fetch
    en = 1'b1;
    tick(); check("seq1", pc, 32'hBFC00004);
    tick(); check("seq2", pc, 32'hBFC00008);
    tick(); check("seq3", pc, 32'hBFC0000C);

    // Branch without stall
    branch_valid = 1'b1; branch_target = 32'hBFC00100;
    tick(); check("br_pc", pc, 32'hBFC00100);
    check("br_pend", {31'd0, redirect_pending}, 32'd0);
    branch_valid = 1'b0;
    tick(); check("br_seq1", pc, 32'hBFC00104);
    tick(); check("br_seq2", pc, 32'hBFC00108);

    // Branch under stall; second branch ignored
    en = 1'b0; branch_valid = 1'b1; branch_target = 32'hBFC00200;
    tick(); check("stall1_pc", pc, 32'hBFC00108);
    check("stall1_pend", {31'd0, redirect_pending}, 32'd1);
    branch_target = 32'hBFC00300;
    tick(); check("stall2_pc", pc, 32'hBFC00108);
    check("stall2_pend", {31'd0, redirect_pending}, 32'd1);
    branch_valid = 1'b0;
    tick(); check("stall3_pc", pc, 32'hBFC00108);
    en = 1'b1;
    tick(); check("release_pc", pc, 32'hBFC00200);
    check("release_pend", {31'd0, redirect_pending}, 32'd0);
    tick(); check("release_seq", pc, 32'hBFC00204);

    // Exception overrides stall and pending target
    en = 1'b0; branch_valid = 1'b1; branch_target = 32'hBFC00500;
    tick(); check("hold_again", {31'd0, redirect_pending}, 32'd1);
    branch_valid = 1'b0; exc_valid = 1'b1; exc_eret = 1'b0;
    tick(); check("exc_pc", pc, 32'hBFC00380);
    check("exc_pend", {31'd0, redirect_pending}, 32'd0);
    exc_eret = 1'b1; epc = 32'h80001234;
    tick(); check("eret_pc", pc, 32'h80001234);
    check("eret_mis", {31'd0, pc_misaligned}, 32'd0);
    epc = 32'h80001236;
    tick(); check("eret_mis_pc", pc, 32'h80001236);
    check("eret_mis1", {31'd0, pc_misaligned}, 32'd1);
    exc_valid = 1'b0; exc_eret = 1'b0;
    tick(); check("post_exc_hold", pc, 32'h80001236);
    en = 1'b1;
    tick(); check("discarded_tgt", pc, 32'h8000123A);
    check("mis_still", {31'd0, pc_misaligned}, 32'd1);

    // Exception beats a simultaneous enabled branch
    exc_valid = 1'b1; branch_valid = 1'b1; branch_target = 32'hBFC00700;
    tick(); check("exc_vs_br", pc, 32'hBFC00380);
    exc_valid = 1'b0;

    // Wrap-around
    branch_target = 32'hFFFFFFFC;
    tick(); check("wrap_pre_pc", pc, 32'hFFFFFFFC);
    check("wrap_pre_inc", pc_plus_inc, 32'h00000000);
    branch_valid = 1'b0;
    tick(); check("wrap_pc", pc, 32'h00000000);
    check("wrap_inc", pc_plus_inc, 32'h00000004);

    // Async reset while holding a branch
    en = 1'b0; branch_valid = 1'b1; branch_target = 32'hBFC00900;
    tick(); check("pre_rst_pend", {31'd0, redirect_pending}, 32'd1);
    check("pre_rst_pc", pc, 32'h00000000);
    branch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'hBFC00000);
    check("async_rst_pend", {31'd0, redirect_pending}, 32'd0);
    tick();
    rst = 1'b0; en = 1'b1;
    tick(); check("after_rst_pc", pc, 32'hBFC00004);
    check("after_rst_pend", {31'd0, redirect_pending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage of the MIPS core.
- Replaces the plain enable register with a block that owns next-PC selection: sequential increment, branch/jump redirect, exception vector and ERET return.
- Holds a branch redirect that arrives during a stall until fetch may advance.
- Feeds the instruction SRAM address and the IF/ID pc register.

Parameters:
- WIDTH, 32, PC width in bits (>= 3).
- RESET_VECTOR, 32'hBFC00000, PC value after reset.
- EXC_VECTOR, 32'hBFC00380, general exception entry.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch advance; 0 = pipeline stall.
- branch_valid  in  1  decode resolved a taken branch/jump this cycle.
- branch_target  in  WIDTH  redirect target.
- exc_valid  in  1  exception/ERET commit from memory stage (flush).
- exc_eret  in  1  qualifies exc_valid: 1 = ERET, 0 = exception.
- epc  in  WIDTH  CP0 EPC value used on ERET.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus_inc  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
- redirect_pending  out  1  a stalled branch target is held.
- pc_misaligned  out  1  pc[1:0] != 0 (AdEL source), combinational.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: pc = RESET_VECTOR; state = RUN; held target = 0; redirect_pending = 0; pc_misaligned = 0 for an aligned vector.
- States:
  - RUN: normal fetch.
  - HOLD_BR: a branch target is latched, waiting for en.
- Priority at each rising edge (highest first):
  1. exc_valid=1: pc <= exc_eret ? epc : EXC_VECTOR. State -> RUN and the held target is discarded. This applies regardless of en or branch_valid, because the flush overrides the stall.
  2. RUN, branch_valid=1, en=1: pc <= branch_target.
  3. RUN, branch_valid=1, en=0: pc holds. Latch branch_target; state -> HOLD_BR.
  4. RUN, branch_valid=0, en=1: pc <= pc + INC. Wraps modulo 2^WIDTH, no carry out.
  5. RUN, en=0: pc holds.
  6. HOLD_BR, en=1: pc <= held target; state -> RUN.
  7. HOLD_BR, en=0: hold everything.
- branch_valid while in HOLD_BR is ignored (a branch in a delay slot is architecturally undefined).
- Delay slot: decode asserts branch_valid while pc already addresses the delay slot. One enabled edge therefore fetches the delay slot, and the next edge lands on the target. No extra bubble is inserted.
- Latency: a redirect is visible on pc one edge after acceptance (branch_valid & en, or the HOLD_BR release, or exc_valid).
- redirect_pending = (state == HOLD_BR), registered.
- Misaligned targets (branch, epc) are loaded unmodified; the only effect is pc_misaligned=1. Raising the exception is the CP0 logic's job.
- Reset asserted mid-operation: immediate return to the reset values, including while in HOLD_BR. The first fetch after deassertion is RESET_VECTOR.

Decomposition:
- Package pc_pkg:
  - state enum {RUN, HOLD_BR}
  - default RESET_VECTOR and EXC_VECTOR constants
  - INC default
- Sub-module pc_redirect_hold: WIDTH-wide target register plus valid flag, with load/clear/release controls. It is instantiated once; the next-PC mux and the state logic stay in pc_gen.

Test Plan:
- Reset/sequential: rst pulse, then en=1 for 3 cycles -> pc sequence BFC00000, BFC00004, BFC00008, BFC0000C.
- Branch, no stall: pc=BFC00004, branch_valid=1, target=BFC00100, en=1 -> next pc=BFC00100, redirect_pending stays 0.
- Branch under stall: pc=BFC00008, branch_valid=1, target=BFC00200, en=0 for 3 cycles -> pc holds BFC00008 and redirect_pending=1. A second branch_valid with target=BFC00300 during the stall is ignored. en=1 -> pc=BFC00200, redirect_pending=0.
- Exception overrides stall and pending: in HOLD_BR with en=0, exc_valid=1, exc_eret=0 -> pc=BFC00380, redirect_pending=0. Then exc_valid=1, exc_eret=1, epc=80001234 -> pc=80001234, pc_misaligned=0. epc=80001236 -> pc_misaligned=1.
- Wrap: WIDTH=32, force pc=FFFFFFFC via branch, en=1 -> pc=00000000, pc_plus_inc=00000004.
- Async reset mid-HOLD_BR: assert rst between clock edges -> pc=BFC00000 and redirect_pending=0 before the next edge. After release with en=1 -> BFC00004.
